reg_write_arbiter: RTL



---
 rtl/reg_write_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter sharing one N-bit register among M
//                requesters. It grants at most one requester per cycle and
//                loads that requester's data on the next rising edge. It also
//                records which requester made the last write.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int N    = 8,
  parameter int M    = 4,
  parameter int ID_W = $clog2(M)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [M-1:0]      req,
  input  logic [M*N-1:0]    wdata,
  output logic [M-1:0]      grant,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic [ID_W-1:0]   last_id
);

  // Round-robin pointer: the requester that currently has the highest priority.
  // It always stays below M, including when M is not a power of two.
  logic [ID_W-1:0] r_ptr;

  // Index of the granted requester. It is only meaningful when w_any is high.
  logic [ID_W-1:0] w_gidx;
  logic            w_any;

  // Scan the requesters from ptr upward, wrapping modulo M.
  // The first active request wins. Reset forces the grant low.
  always_comb begin : p_grant
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant  = '0;
    w_gidx = '0;
    w_any  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int off = 0; off < M; off++) begin
      idx = int'(r_ptr) + off;
      if (idx >= M) idx = idx - M;
      idx_w = ID_W'(idx);
      if (!w_any && req[idx_w]) begin
        w_any         = 1'b1;
        w_gidx        = idx_w;
        grant[idx_w]  = 1'b1;
      end
    end
    if (!n_reset) begin
      grant = '0;
      w_any = 1'b0;
    end
  end

  // Capture the granted requester's data and advance the pointer past it.
  // On an idle cycle, everything holds.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      last_id <= '0;
      r_ptr   <= '0;
    end else if (w_any) begin
      q       <= wdata[w_gidx*N +: N];
      q_valid <= 1'b1;
      last_id <= w_gidx;
      // The wrap happens at M rather than at 2^ID_W.
      if (w_gidx == ID_W'(M - 1)) r_ptr <= '0;
      else                        r_ptr <= w_gidx + ID_W'(1);
    end
  end

endmodule
`default_nettype wire
